// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Brief    : Drives PLL reset, supervises lock with bounded retries and
//            releases the system reset once lock has been stable long enough.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       req_restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       pll_ready,
    output logic       lock_fail,
    output logic [3:0] retry_count
);

    localparam int c_cnt_max_ab = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                  RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int c_cnt_max    = (c_cnt_max_ab > LOCK_STABLE_CYCLES) ?
                                  c_cnt_max_ab : LOCK_STABLE_CYCLES;
    localparam int c_cnt_w      = $clog2(c_cnt_max) + 1;

    localparam logic [c_cnt_w-1:0] c_pulse_last   = c_cnt_w'(RST_PULSE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_sat      = c_cnt_w'(c_cnt_max);
    localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
    localparam logic [3:0]         c_max_retries  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PULSE     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_lock_meta;
    logic                 r_lock_sync;
    logic [3:0]           r_retry;
    logic [3:0]           w_next_retry;
    logic                 w_enter;
    logic                 r_pll_rst;
    logic                 r_sys_rst_n;
    logic                 r_pll_ready;
    logic                 r_lock_fail;
    logic                 w_pll_rst;
    logic                 w_sys_rst_n;
    logic                 w_pll_ready;
    logic                 w_lock_fail;

    // pll_locked comes from the PLL with no relation to refclk phase
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry;
        if (req_restart) begin
            w_next_state = S_PULSE;
            w_next_retry = 4'd0;
        end else begin
            case (r_state)
                S_PULSE: begin
                    if (r_cnt == c_pulse_last) begin
                        w_next_state = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    // lock seen on the timeout cycle still counts as lock
                    if (r_lock_sync) begin
                        w_next_state = S_STABILIZE;
                    end else if (r_cnt == c_timeout_last) begin
                        if (r_retry == c_max_retries) begin
                            w_next_state = S_FAIL;
                        end else begin
                            w_next_state = S_PULSE;
                            w_next_retry = r_retry + 4'd1;
                        end
                    end
                end
                S_STABILIZE: begin
                    if (!r_lock_sync) begin
                        w_next_state = S_WAIT_LOCK;
                    end else if (r_cnt == c_stable_last) begin
                        w_next_state = S_RUN;
                        w_next_retry = 4'd0;
                    end
                end
                S_RUN: begin
                    if (!r_lock_sync) begin
                        w_next_state = S_PULSE;
                    end
                end
                S_FAIL: begin
                    w_next_state = S_FAIL;
                end
                default: begin
                    w_next_state = S_PULSE;
                end
            endcase
        end
    end

    // Any entry, including a restart that re-enters PULSE, restarts the count
    assign w_enter = req_restart || (w_next_state != r_state);

    always_comb begin
        w_pll_rst   = 1'b1;
        w_sys_rst_n = 1'b0;
        w_pll_ready = 1'b0;
        w_lock_fail = 1'b0;
        case (w_next_state)
            S_WAIT_LOCK, S_STABILIZE: begin
                w_pll_rst = 1'b0;
            end
            S_RUN: begin
                w_pll_rst   = 1'b0;
                w_sys_rst_n = 1'b1;
                w_pll_ready = 1'b1;
            end
            S_FAIL: begin
                w_lock_fail = 1'b1;
            end
            default: begin
                w_pll_rst = 1'b1;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_PULSE;
            r_cnt       <= '0;
            r_retry     <= 4'd0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_pll_ready <= 1'b0;
            r_lock_fail <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_retry     <= w_next_retry;
            r_pll_rst   <= w_pll_rst;
            r_sys_rst_n <= w_sys_rst_n;
            r_pll_ready <= w_pll_ready;
            r_lock_fail <= w_lock_fail;
            if (w_enter) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_sat) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign pll_rst     = r_pll_rst;
    assign sys_rst_n   = r_sys_rst_n;
    assign pll_ready   = r_pll_ready;
    assign lock_fail   = r_lock_fail;
    assign retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Brief    : Directed, table-driven self-checking bench for pll_reset_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       req_restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       pll_ready;
    logic       lock_fail;
    logic [3:0] retry_count;
    logic [7:0] w_obs;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         edges;
        logic       locked;
        logic       restart;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (50),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .req_restart (req_restart),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .pll_ready   (pll_ready),
        .lock_fail   (lock_fail),
        .retry_count (retry_count)
    );

    assign w_obs = {pll_rst, sys_rst_n, pll_ready, lock_fail, retry_count};

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1);
    end

    function automatic logic [7:0] outs(input int pr, input int sr, input int rdy,
                                        input int fl, input int rc);
        return {1'(pr), 1'(sr), 1'(rdy), 1'(fl), 4'(rc)};
    endfunction

    function automatic void add(input int edges, input int locked, input int restart,
                                input logic [7:0] exp, input string name);
        vec_t v;
        v.edges   = edges;
        v.locked  = 1'(locked);
        v.restart = 1'(restart);
        v.exp     = exp;
        v.name    = name;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        n_checks++;
        if (w_obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pll_rst=%b sys_rst_n=%b pll_ready=%b lock_fail=%b retry=%0d, required pll_rst=%b sys_rst_n=%b pll_ready=%b lock_fail=%b retry=%0d",
                     name, w_obs[7], w_obs[6], w_obs[5], w_obs[4], w_obs[3:0],
                     exp[7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Called at a falling edge: drive inputs, advance n rising edges, sample at next falling edge
    task automatic cycle(input int n, input logic locked, input logic restart,
                         input logic [7:0] exp, input string name);
        pll_locked  = locked;
        req_restart = restart;
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1 req_restart = 1'b0;
        end
        @(negedge refclk);
        check(name, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        pll_locked  = 1'b0;
        req_restart = 1'b0;

        // Normal bring-up: lock raised 10 cycles after pll_rst falls
        add(3,  0, 0, outs(1, 0, 0, 0, 0), "bring_pulse_hi");
        add(1,  0, 0, outs(0, 0, 0, 0, 0), "bring_pulse_end");
        add(10, 0, 0, outs(0, 0, 0, 0, 0), "bring_wait");
        add(10, 1, 0, outs(0, 0, 0, 0, 0), "bring_stab");
        add(1,  1, 0, outs(0, 1, 1, 0, 0), "bring_run");
        add(5,  1, 0, outs(0, 1, 1, 0, 0), "run_hold");
        // Loss of lock in RUN: seen on third edge after the drop
        add(2,  0, 0, outs(0, 1, 1, 0, 0), "loss_sync");
        add(1,  0, 0, outs(1, 0, 0, 0, 0), "loss_drop");
        add(3,  0, 0, outs(1, 0, 0, 0, 0), "loss_pulse_hi");
        add(1,  0, 0, outs(0, 0, 0, 0, 0), "loss_pulse_end");
        add(10, 1, 0, outs(0, 0, 0, 0, 0), "relock_stab");
        add(1,  1, 0, outs(0, 1, 1, 0, 0), "relock_run");
        // Lock chatter mid-window: full stable window needed after re-lock
        add(1,  0, 1, outs(1, 0, 0, 0, 0), "chat_restart");
        add(3,  0, 0, outs(1, 0, 0, 0, 0), "chat_pulse_hi");
        add(1,  0, 0, outs(0, 0, 0, 0, 0), "chat_pulse_end");
        add(6,  1, 0, outs(0, 0, 0, 0, 0), "chat_stab");
        add(3,  0, 0, outs(0, 0, 0, 0, 0), "chat_drop");
        add(10, 1, 0, outs(0, 0, 0, 0, 0), "chat_rewindow");
        add(1,  1, 0, outs(0, 1, 1, 0, 0), "chat_run");
        // Lock never arrives: three attempts then FAIL
        add(1,  0, 1, outs(1, 0, 0, 0, 0), "nolock_restart");
        add(3,  0, 0, outs(1, 0, 0, 0, 0), "nolock_p0_hi");
        add(1,  0, 0, outs(0, 0, 0, 0, 0), "nolock_p0_end");
        add(49, 0, 0, outs(0, 0, 0, 0, 0), "nolock_wait0");
        add(1,  0, 0, outs(1, 0, 0, 0, 1), "nolock_retry1");
        add(3,  0, 0, outs(1, 0, 0, 0, 1), "nolock_p1_hi");
        add(1,  0, 0, outs(0, 0, 0, 0, 1), "nolock_p1_end");
        add(49, 0, 0, outs(0, 0, 0, 0, 1), "nolock_wait1");
        add(1,  0, 0, outs(1, 0, 0, 0, 2), "nolock_retry2");
        add(3,  0, 0, outs(1, 0, 0, 0, 2), "nolock_p2_hi");
        add(1,  0, 0, outs(0, 0, 0, 0, 2), "nolock_p2_end");
        add(49, 0, 0, outs(0, 0, 0, 0, 2), "nolock_wait2");
        add(1,  0, 0, outs(1, 0, 0, 1, 2), "fail_enter");
        add(20, 0, 0, outs(1, 0, 0, 1, 2), "fail_hold");
        // Restart out of FAIL, then successful bring-up
        add(1,  0, 1, outs(1, 0, 0, 0, 0), "fail_restart");
        add(3,  0, 0, outs(1, 0, 0, 0, 0), "fail_rs_pulse_hi");
        add(1,  0, 0, outs(0, 0, 0, 0, 0), "fail_rs_pulse_end");
        add(10, 1, 0, outs(0, 0, 0, 0, 0), "fail_rs_stab");
        add(1,  1, 0, outs(0, 1, 1, 0, 0), "fail_rs_run");
        // Synchronised lock arrives on the exact timeout cycle
        add(1,  0, 1, outs(1, 0, 0, 0, 0), "race_restart");
        add(3,  0, 0, outs(1, 0, 0, 0, 0), "race_pulse_hi");
        add(1,  0, 0, outs(0, 0, 0, 0, 0), "race_pulse_end");
        add(47, 0, 0, outs(0, 0, 0, 0, 0), "race_wait");
        add(2,  1, 0, outs(0, 0, 0, 0, 0), "race_sync");
        add(1,  1, 0, outs(0, 0, 0, 0, 0), "race_edge");
        add(7,  1, 0, outs(0, 0, 0, 0, 0), "race_stab");
        add(1,  1, 0, outs(0, 1, 1, 0, 0), "race_run");

        repeat (3) @(posedge refclk);
        @(negedge refclk);
        check("reset_state", outs(1, 0, 0, 0, 0));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].edges, vecs[i].locked, vecs[i].restart, vecs[i].exp, vecs[i].name);
        end

        // Asynchronous reset while in STABILIZE
        cycle(1, 1'b0, 1'b1, outs(1, 0, 0, 0, 0), "stz_restart");
        cycle(3, 1'b0, 1'b0, outs(1, 0, 0, 0, 0), "stz_pulse_hi");
        cycle(1, 1'b0, 1'b0, outs(0, 0, 0, 0, 0), "stz_pulse_end");
        cycle(5, 1'b1, 1'b0, outs(0, 0, 0, 0, 0), "stz_in_window");
        #2 rst_n = 1'b0;
        #1 check("stz_async_rst", outs(1, 0, 0, 0, 0));
        repeat (2) @(posedge refclk);
        @(negedge refclk);
        check("stz_rst_hold", outs(1, 0, 0, 0, 0));
        rst_n = 1'b1;
        cycle(3, 1'b1, 1'b0, outs(1, 0, 0, 0, 0), "stz_rel_pulse_hi");
        cycle(1, 1'b1, 1'b0, outs(0, 0, 0, 0, 0), "stz_rel_pulse_end");
        cycle(8, 1'b1, 1'b0, outs(0, 0, 0, 0, 0), "stz_rel_stab");
        cycle(1, 1'b1, 1'b0, outs(0, 1, 1, 0, 0), "stz_rel_run");

        // Asynchronous reset while in FAIL
        cycle(1,   1'b0, 1'b1, outs(1, 0, 0, 0, 0), "fr_restart");
        cycle(161, 1'b0, 1'b0, outs(0, 0, 0, 0, 2), "fr_last_wait");
        cycle(1,   1'b0, 1'b0, outs(1, 0, 0, 1, 2), "fr_fail");
        #2 rst_n = 1'b0;
        #1 check("fail_async_rst", outs(1, 0, 0, 0, 0));
        @(posedge refclk);
        @(negedge refclk);
        rst_n = 1'b1;
        cycle(3, 1'b0, 1'b0, outs(1, 0, 0, 0, 0), "fr_rel_pulse_hi");
        cycle(1, 1'b0, 1'b0, outs(0, 0, 0, 0, 0), "fr_rel_pulse_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
